grid_scanner: RTL and testbench

GRID_SCANNER -- requirements
Module: grid_scanner

---
 rtl/game_of_life_pkg.sv | 14 +
 rtl/popcount_49.sv | 17 +
 rtl/grid_scanner.sv | 151 +++++++++++++++
 tb/tb_grid_scanner.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/game_of_life_pkg.sv
// Shared definitions for the Game of Life display path: grid geometry and
// the scanner state encoding.
package game_of_life_pkg;

  localparam int GRID_N    = 7;
  localparam int GRID_BITS = GRID_N * GRID_N;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SCAN  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/popcount_49.sv
// Combinational population count of a full 7x7 grid (0..49).
module popcount_49
  import game_of_life_pkg::*;
(
  input  logic [GRID_BITS-1:0] data_i,
  output logic [5:0]           count_o
);

  // Sum every cell; synthesis turns this into an adder tree.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < GRID_BITS; i++) begin
      count_o = count_o + 6'(data_i[i]);
    end
  end

endmodule

// File: rtl/grid_scanner.sv
// Row-multiplexed LED scanner for the 7x7 grid. Incoming generations are
// parked in a pending buffer and only promoted to the display buffer at a
// frame boundary, so a frame never shows two generations at once.
module grid_scanner
  import game_of_life_pkg::*;
#(
  parameter int DWELL = 1000,
  parameter int BLANK = 4
) (
  input  logic                 clka,
  input  logic                 rst_n,
  input  logic [GRID_BITS-1:0] grid,
  input  logic                 grid_valid,
  input  logic                 enable,
  output logic [GRID_N-1:0]    row_sel,
  output logic [GRID_N-1:0]    col_data,
  output logic                 frame_done,
  output logic [5:0]           alive_count
);

  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [2:0] LAST_ROW = 3'(GRID_N - 1);

  scan_state_e          state_q, state_d;
  logic [2:0]           row_q, row_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [GRID_BITS-1:0] pend_q, pend_d;
  logic                 pend_flag_q, pend_flag_d;
  logic [GRID_BITS-1:0] disp_q, disp_d;
  logic [GRID_N-1:0]    row_sel_q, row_sel_d;
  logic [GRID_N-1:0]    col_data_q, col_data_d;
  logic                 frame_done_q, frame_done_d;
  logic [5:0]           alive_q;
  logic [5:0]           pop_count;

  popcount_49 u_popcount (
    .data_i  (disp_q),
    .count_o (pop_count)
  );

  // Next-state: scan sequencing, buffer handoff and registered output drive.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves a latch.
    state_d      = state_q;
    row_d        = row_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_flag_d  = pend_flag_q;
    disp_d       = disp_q;
    frame_done_d = 1'b0;

    // A strobe always lands in pending; the frame boundary may override.
    if (grid_valid) begin
      pend_d      = grid;
      pend_flag_d = 1'b1;
    end

    if (!enable) begin
      state_d = ST_IDLE;
      row_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          row_d   = '0;
          cnt_d   = '0;
          if (pend_flag_q) begin
            disp_d      = pend_q;
            pend_flag_d = grid_valid;
          end
        end
        ST_BLANK: begin
          if (cnt_q == CW'(BLANK - 1)) begin
            state_d = ST_SCAN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SCAN: begin
          if (cnt_q == CW'(DWELL - 1)) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (row_q == LAST_ROW) begin
              row_d        = '0;
              frame_done_d = 1'b1;
              // Frame boundary: a same-edge strobe bypasses pending entirely.
              if (grid_valid) begin
                disp_d      = grid;
                pend_flag_d = 1'b0;
              end else if (pend_flag_q) begin
                disp_d      = pend_q;
                pend_flag_d = 1'b0;
              end
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs follow the next state so they line up with the state register.
    row_sel_d  = '0;
    col_data_d = '0;
    if (state_d == ST_SCAN) begin
      row_sel_d  = GRID_N'(1) << row_d;
      col_data_d = disp_d[int'(row_d) * GRID_N +: GRID_N];
    end
  end

  // State and output registers; reset blanks the display immediately.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      cnt_q        <= '0;
      // NOTE: the frame buffers are reset too, so a fresh start never flashes stale cells.
      pend_q       <= '0;
      pend_flag_q  <= 1'b0;
      disp_q       <= '0;
      row_sel_q    <= '0;
      col_data_q   <= '0;
      frame_done_q <= 1'b0;
      alive_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_flag_q  <= pend_flag_d;
      disp_q       <= disp_d;
      row_sel_q    <= row_sel_d;
      col_data_q   <= col_data_d;
      frame_done_q <= frame_done_d;
      alive_q      <= pop_count;
    end
  end

  assign row_sel     = row_sel_q;
  assign col_data    = col_data_q;
  assign frame_done  = frame_done_q;
  assign alive_count = alive_q;

endmodule

// File: tb/tb_grid_scanner.sv
// Self-checking bench for grid_scanner (DWELL=4, BLANK=1). The reference
// model tracks time since scanning started and derives row/column drive from
// frame-position arithmetic.
module tb_grid_scanner;

  localparam int DW      = 4;
  localparam int BL      = 1;
  localparam int ROW_P   = DW + BL;
  localparam int FRAME_P = 7 * ROW_P;

  localparam logic [48:0] ALL_ON  = 49'h1_FFFF_FFFF_FFFF;
  localparam logic [48:0] GLIDER  = 49'h0_0000_0001_C202;
  localparam logic [48:0] ONE_BIT = 49'h0_0000_0000_0001;
  localparam logic [48:0] ROW0    = 49'h0_0000_0000_007F;

  logic        clka = 1'b0;
  logic        rst_n;
  logic [48:0] grid;
  logic        grid_valid;
  logic        enable;
  logic [6:0]  row_sel;
  logic [6:0]  col_data;
  logic        frame_done;
  logic [5:0]  alive_count;

  grid_scanner #(.DWELL(DW), .BLANK(BL)) dut (
    .clka        (clka),
    .rst_n       (rst_n),
    .grid        (grid),
    .grid_valid  (grid_valid),
    .enable      (enable),
    .row_sel     (row_sel),
    .col_data    (col_data),
    .frame_done  (frame_done),
    .alive_count (alive_count)
  );

  always #5 clka = ~clka;

  int checks = 0;
  int passes = 0;
  int cycle  = 0;

  // Reference model: m_t < 0 means idle, otherwise cycles since scan start.
  logic [48:0] m_disp, m_pend;
  bit          m_flag;
  int          m_t;
  int          m_alive;
  bit          m_fd;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, exp);
  endtask

  task automatic model_reset();
    m_disp = '0; m_pend = '0; m_flag = 1'b0; m_t = -1; m_alive = 0; m_fd = 1'b0;
  endtask

  task automatic model_edge(input bit en, input bit gv, input logic [48:0] g);
    bit boundary;
    m_alive  = $countones(m_disp);
    boundary = (m_t >= 0) && (m_t % FRAME_P == FRAME_P - 1);
    m_fd     = 1'b0;
    if (!en) begin
      m_t = -1;
      if (gv) begin m_pend = g; m_flag = 1'b1; end
    end else if (m_t < 0) begin
      if (m_flag) begin m_disp = m_pend; m_flag = 1'b0; end
      if (gv) begin m_pend = g; m_flag = 1'b1; end
      m_t = 0;
    end else begin
      if (boundary) begin
        m_fd = 1'b1;
        if (gv) begin m_disp = g; m_flag = 1'b0; end
        else if (m_flag) begin m_disp = m_pend; m_flag = 1'b0; end
      end else if (gv) begin
        m_pend = g; m_flag = 1'b1;
      end
      m_t++;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [6:0] e_row, e_col;
    int p, r;
    e_row = '0; e_col = '0;
    if (m_t >= 0) begin
      p = m_t % FRAME_P;
      r = p / ROW_P;
      if (p % ROW_P >= BL) begin
        e_row = 7'(1 << r);
        e_col = m_disp[r*7 +: 7];
      end
    end
    check_val({tag, ".row_sel"},     32'(row_sel),     32'(e_row));
    check_val({tag, ".col_data"},    32'(col_data),    32'(e_col));
    check_val({tag, ".frame_done"},  32'(frame_done),  32'(m_fd));
    check_val({tag, ".alive_count"}, 32'(alive_count), 32'(m_alive));
  endtask

  task automatic step(input string tag, input bit en, input bit gv, input logic [48:0] g);
    enable = en; grid_valid = gv; grid = g;
    @(posedge clka);
    #1;
    cycle++;
    model_edge(en, gv, g);
    check_outputs(tag);
    grid_valid = 1'b0;
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, '0);
  endtask

  // Advance with enable high until the model sits at frame position p.
  task automatic run_until(input string tag, input int p);
    int guard = 0;
    while ((m_t < 0 || m_t % FRAME_P != p) && guard < 3 * FRAME_P) begin
      step(tag, 1'b1, 1'b0, '0);
      guard++;
    end
    check_val({tag, ".reach_pos"}, 32'(guard < 3 * FRAME_P), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, ".row_sel"},     32'(row_sel),     32'd0);
    check_val({tag, ".col_data"},    32'(col_data),    32'd0);
    check_val({tag, ".frame_done"},  32'(frame_done),  32'd0);
    check_val({tag, ".alive_count"}, 32'(alive_count), 32'd0);
  endtask

  initial begin
    int fd_first, fd_second;
    logic [48:0] g;

    // Power-on reset, checked before any clock edge.
    rst_n = 1'b0; enable = 1'b0; grid_valid = 1'b0; grid = '0;
    model_reset();
    #2;
    check_reset_outputs("por");
    @(negedge clka); @(negedge clka);
    rst_n = 1'b1;
    step("idle", 1'b0, 1'b0, '0);
    step("idle", 1'b0, 1'b0, '0);

    // Scan order with a full grid; measure frame_done spacing.
    step("scan_strobe", 1'b0, 1'b1, ALL_ON);
    fd_first = -1; fd_second = -1;
    for (int i = 0; i < 2 * FRAME_P + 5; i++) begin
      step("scan", 1'b1, 1'b0, '0);
      if (frame_done === 1'b1) begin
        if (fd_first < 0) fd_first = cycle;
        else if (fd_second < 0) fd_second = cycle;
      end
    end
    check_val("frame_period", 32'(fd_second - fd_first), 32'(FRAME_P));
    check_val("alive_full", 32'(alive_count), 32'd49);

    // No tearing: glider shown, then a single-cell grid strobed during row 2.
    step("glider_strobe", 1'b1, 1'b1, GLIDER);
    run_until("glider_wait", 0);
    run_until("glider_row2", 2 * ROW_P + 2);
    step("tear_strobe", 1'b1, 1'b1, ONE_BIT);
    run("tear", FRAME_P + 10);
    check_val("alive_one", 32'(alive_count), 32'd1);

    // Strobe on the frame-boundary edge bypasses pending; an earlier
    // pending grid must not appear afterwards.
    run_until("bypass_pre", 10);
    step("bypass_pend", 1'b1, 1'b1, GLIDER);
    run_until("bypass_wait", FRAME_P - 1);
    step("bypass_edge", 1'b1, 1'b1, ROW0);
    run("bypass", 2 * FRAME_P);
    check_val("bypass_alive", 32'(alive_count), 32'd7);

    // Enable drop during row 5 scan, then restart from row 0.
    run_until("drop_wait", 5 * ROW_P + 2);
    step("drop", 1'b0, 1'b0, '0);
    step("drop_idle", 1'b0, 1'b0, '0);
    step("drop_idle", 1'b0, 1'b0, '0);
    run("restart", FRAME_P + 3);

    // Back-to-back strobes: only the second survives.
    run_until("b2b_wait", 8);
    step("b2b_x", 1'b1, 1'b1, ALL_ON);
    step("b2b_y", 1'b1, 1'b1, GLIDER);
    run("b2b", 2 * FRAME_P);
    check_val("b2b_alive", 32'(alive_count), 32'd5);

    // Asynchronous reset mid-scan on row 3.
    run_until("rst_wait", 3 * ROW_P + 2);
    check_val("rst_pre_lit", 32'(row_sel), 32'h08);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("rst_mid");
    model_reset();
    enable = 1'b0;
    @(negedge clka);
    rst_n = 1'b1;
    step("rst_idle", 1'b0, 1'b0, '0);
    step("rst_idle", 1'b0, 1'b0, '0);

    // Randomised traffic: strobes, enable drops, arbitrary grids.
    for (int i = 0; i < 800; i++) begin
      g = 49'({$urandom(), $urandom()});
      step("rand", ($urandom_range(0, 19) != 0), ($urandom_range(0, 7) == 0), g);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
